// File: rtl/mult_controller_pkg.sv
// Shared definitions for the multi-cycle HI/LO multiplier controller:
// FSM state encoding and the decode-stage move-from request encodings.
package mult_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mult_state_t;

    localparam logic [1:0] MF_NONE = 2'b00;
    localparam logic [1:0] MF_HI   = 2'b01;
    localparam logic [1:0] MF_LO   = 2'b10;

endpackage

// File: rtl/mult_shift_add.sv
// Radix-2 shift-add datapath: operates on operand magnitudes, then applies
// the sign at the output so the FSM can commit the final 2*WIDTH-bit result.
module mult_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 signed_mult,
    input  logic [WIDTH-1:0]     src_a,
    input  logic [WIDTH-1:0]     src_b,
    output logic [2*WIDTH-1:0]   result
);
    import mult_controller_pkg::*;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic               negate;

    // The most-negative value maps onto itself, which is the correct
    // unsigned magnitude, so no overflow handling is needed.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             s);
        return (s && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            negate <= 1'b0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, magnitude(src_a, signed_mult)};
            mplier <= magnitude(src_b, signed_mult);
            acc    <= '0;
            negate <= signed_mult & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        end else if (step) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign result = negate ? -acc : acc;

endmodule

// File: rtl/mult_controller.sv
// Multi-cycle multiply unit owning the architectural HI/LO registers; stalls
// the front end while a multiply is in flight and a dependent request arrives.
module mult_controller #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startMultE,
    input  logic             signedMultE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic [1:0]       mfRegD,
    output logic             MultStall,
    output logic             MultBusy,
    output logic             MultDone,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut,
    output logic [WIDTH-1:0] MfResultD
);
    import mult_controller_pkg::*;

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    mult_state_t        state, next_state;
    logic [CNT_W-1:0]   count;
    logic               load, step, mf_req;
    logic [2*WIDTH-1:0] result;

    mult_shift_add #(.WIDTH(WIDTH)) u_datapath (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .step        (step),
        .signed_mult (signedMultE),
        .src_a       (SrcAE),
        .src_b       (SrcBE),
        .result      (result)
    );

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // HI/LO only ever move on the DONE edge; reset in flight discards the result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            HiOut <= '0;
            LoOut <= '0;
        end else begin
            if (load)
                count <= '0;
            else if (step)
                count <= count + CNT_W'(1);
            if (state == DONE)
                {HiOut, LoOut} <= result;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (startMultE) next_state = BUSY;
            BUSY:    if (count == LAST_ITER) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load      = (state == IDLE) && startMultE;
        step      = (state == BUSY);
        MultBusy  = (state != IDLE);
        MultDone  = (state == DONE);
        mf_req    = (mfRegD == MF_HI) || (mfRegD == MF_LO);
        MultStall = MultBusy && (startMultE || mf_req);
        case (mfRegD)
            MF_HI:   MfResultD = HiOut;
            MF_LO:   MfResultD = LoOut;
            default: MfResultD = '0;
        endcase
    end

endmodule

// File: tb/tb_mult_controller.sv
// Directed and randomized checks of mult_controller against a plain
// arithmetic product model of HI/LO.
module tb_mult_controller;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          startMultE;
    logic          signedMultE;
    logic [W-1:0]  SrcAE, SrcBE;
    logic [1:0]    mfRegD;
    logic          MultStall, MultBusy, MultDone;
    logic [W-1:0]  HiOut, LoOut, MfResultD;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    mult_controller #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .startMultE  (startMultE),
        .signedMultE (signedMultE),
        .SrcAE       (SrcAE),
        .SrcBE       (SrcBE),
        .mfRegD      (mfRegD),
        .MultStall   (MultStall),
        .MultBusy    (MultBusy),
        .MultDone    (MultDone),
        .HiOut       (HiOut),
        .LoOut       (LoOut),
        .MfResultD   (MfResultD)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        longint      sa, sb;
        logic [63:0] ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for MultDone after an accepted start; expects exactly W BUSY edges.
    task automatic wait_done(input string tag, input logic check_stall);
        int cnt = 0;
        while (!MultDone && cnt < 100) begin
            if (check_stall) chk({tag, "_stall_busy"}, 64'(MultStall), 64'd1);
            tick();
            cnt++;
        end
        chk({tag, "_done_latency"}, 64'(cnt), 64'(W));
        chk({tag, "_hilo_held"}, {HiOut, LoOut}, {model_hi, model_lo});
    endtask

    task automatic run_mult(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s);
        startMultE  = 1'b1;
        signedMultE = s;
        SrcAE       = a;
        SrcBE       = b;
        tick();
        startMultE = 1'b0;
        SrcAE      = $urandom;
        SrcBE      = $urandom;
        chk({tag, "_busy"}, 64'(MultBusy), 64'd1);
        wait_done(tag, 1'b0);
        tick();
        {model_hi, model_lo} = ref_prod(a, b, s);
        chk({tag, "_hilo"}, {HiOut, LoOut}, {model_hi, model_lo});
        chk({tag, "_idle"}, 64'(MultBusy), 64'd0);
    endtask

    initial begin
        reset       = 1'b0;
        startMultE  = 1'b1;
        signedMultE = 1'b0;
        SrcAE       = 32'h1234_5678;
        SrcBE       = 32'h9abc_def0;
        mfRegD      = 2'b01;
        tick();
        tick();
        chk("rst_flags", {61'b0, MultStall, MultBusy, MultDone}, 64'd0);
        chk("rst_hilo", {HiOut, LoOut}, 64'd0);
        chk("rst_mfhi", 64'(MfResultD), 64'd0);
        mfRegD = 2'b10;
        #1;
        chk("rst_mflo", 64'(MfResultD), 64'd0);
        startMultE = 1'b0;
        mfRegD     = 2'b00;
        reset      = 1'b1;
        tick();

        run_mult("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("umax_const", {HiOut, LoOut}, 64'hFFFF_FFFE_0000_0001);
        run_mult("s_m3x7", 32'hFFFF_FFFD, 32'd7, 1'b1);
        chk("s_m3x7_const", {HiOut, LoOut}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_mult("u_m3x7", 32'hFFFF_FFFD, 32'd7, 1'b0);
        chk("u_m3x7_const", {HiOut, LoOut}, 64'h0000_0006_FFFF_FFEB);
        run_mult("s_minneg", 32'h8000_0000, 32'h8000_0000, 1'b1);
        chk("s_minneg_const", {HiOut, LoOut}, 64'h4000_0000_0000_0000);
        run_mult("s_zero", 32'd0, 32'hFFFF_FFF0, 1'b1);

        mfRegD = 2'b01;
        #1;
        chk("idle_mfhi", 64'(MfResultD), 64'(model_hi));
        chk("idle_mf_nostall", 64'(MultStall), 64'd0);
        mfRegD = 2'b11;
        #1;
        chk("mf11_zero", 64'(MfResultD), 64'd0);
        mfRegD = 2'b00;

        // mflo request raised mid-multiply stalls until the result lands
        startMultE  = 1'b1;
        signedMultE = 1'b0;
        SrcAE       = 32'd123456;
        SrcBE       = 32'd654321;
        tick();
        startMultE = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        mfRegD = 2'b10;
        #1;
        begin
            int cnt = 5;
            while (!MultDone && cnt < 100) begin
                chk("mflo_stall", 64'(MultStall), 64'd1);
                tick();
                cnt++;
            end
            chk("mflo_latency", 64'(cnt), 64'(W));
        end
        chk("mflo_stall_done", 64'(MultStall), 64'd1);
        tick();
        {model_hi, model_lo} = ref_prod(32'd123456, 32'd654321, 1'b0);
        chk("mflo_release", 64'(MultStall), 64'd0);
        chk("mflo_result", 64'(MfResultD), 64'(model_lo));
        mfRegD = 2'b00;

        // reset during BUSY abandons the operation and clears HI/LO
        startMultE  = 1'b1;
        signedMultE = 1'b1;
        SrcAE       = 32'h1234_5678;
        SrcBE       = 32'd9;
        tick();
        startMultE = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_hi = '0;
        model_lo = '0;
        chk("midrst_busy", 64'(MultBusy), 64'd0);
        chk("midrst_hilo", {HiOut, LoOut}, 64'd0);
        for (int i = 0; i < 40; i++) tick();
        chk("midrst_no_commit", {HiOut, LoOut}, 64'd0);
        run_mult("after_rst", 32'd2, 32'd3, 1'b0);
        chk("after_rst_const", 64'(LoOut), 64'd6);

        // a second start held through BUSY/DONE is taken the first IDLE cycle
        startMultE  = 1'b1;
        signedMultE = 1'b0;
        SrcAE       = 32'd7;
        SrcBE       = 32'd9;
        tick();
        SrcAE = 32'd5;
        SrcBE = 32'd5;
        #1;
        wait_done("held", 1'b1);
        chk("held_stall_done", 64'(MultStall), 64'd1);
        tick();
        {model_hi, model_lo} = ref_prod(32'd7, 32'd9, 1'b0);
        chk("held_first", {HiOut, LoOut}, {model_hi, model_lo});
        chk("held_idle_nostall", {62'b0, MultStall, MultBusy}, 64'd0);
        tick();
        startMultE = 1'b0;
        chk("held_accepted", 64'(MultBusy), 64'd1);
        wait_done("held2", 1'b0);
        tick();
        {model_hi, model_lo} = ref_prod(32'd5, 32'd5, 1'b0);
        chk("held_second", {HiOut, LoOut}, {model_hi, model_lo});
        chk("held_second_const", 64'(LoOut), 64'd25);

        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] a, b;
            logic         s;
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            if (i == 0) a = 32'h8000_0000;
            run_mult($sformatf("rand%0d", i), a, b, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mult_controller.md
MULT_CONTROLLER -- requirements
Module: mult_controller

Interface
REQ-001 Parameter: WIDTH, default 32, operand width; product is 2*WIDTH bits; HI/LO are WIDTH bits each.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-low; 0 sampled at clk edge resets the block.
REQ-004 startMultE  input  1  multiply request from execute stage.
REQ-005 signedMultE  input  1  1 = signed (mult), 0 = unsigned (multu); sampled with startMultE.
REQ-006 SrcAE, SrcBE  input  WIDTH  multiplicand and multiplier.
REQ-007 mfRegD  input  2  decode-stage move request: 00 none, 01 mfhi, 10 mflo, 11 treated as none.
REQ-008 MultStall  output  1  stall request to the hazard logic; freezes F/D/E buffers.
REQ-009 MultBusy  output  1  high whenever state is not IDLE.
REQ-010 MultDone  output  1  one-cycle pulse while in DONE.
REQ-011 HiOut, LoOut  output  WIDTH  architectural HI/LO registers.
REQ-012 MfResultD  output  WIDTH  HiOut if mfRegD=01, LoOut if 10, else 0; combinational.

Function
REQ-013 FSM states: IDLE, BUSY, DONE.
REQ-014 IDLE with startMultE=1 at edge N: latch operand magnitudes and negate flag, clear accumulator, counter=0, go BUSY.
REQ-015 Negate flag = signedMultE & (SrcAE[MSB] ^ SrcBE[MSB]); magnitudes = two's-complement absolute value when signed, raw value when unsigned.
REQ-016 Most-negative signed operand (0x80000000) yields magnitude 0x80000000, treated as unsigned; no overflow.
REQ-017 BUSY: one radix-2 shift-add iteration per cycle; counter increments; after WIDTH iterations (counter = WIDTH-1 at edge) go DONE.
REQ-018 DONE edge: {HiOut,LoOut} <= negate ? -product : product (2*WIDTH-bit two's complement); go IDLE.
REQ-019 Latency: start at edge N -> HI/LO updated at edge N+WIDTH+1 (N+33 for WIDTH=32); readable by mfhi/mflo from that edge.
REQ-020 HiOut/LoOut change only at the DONE edge or reset.
REQ-021 MultStall = (state != IDLE) & (startMultE | mfRegD==01 | mfRegD==10).
REQ-022 startMultE while BUSY or DONE is not accepted; MultStall holds it upstream until IDLE, then accepted normally.
REQ-023 Back-to-back: start presented in the first IDLE cycle after DONE is accepted with no gap.
REQ-024 mfRegD request in IDLE: no stall; MfResultD returns current HI/LO same cycle.
REQ-025 Zero operand: full WIDTH iterations still executed; result 0 (negate of 0 is 0).

Reset
REQ-026 reset=0 at an edge: state IDLE, counter 0, accumulator/operand registers 0, HiOut=0, LoOut=0.
REQ-027 Outputs during/after reset: MultStall=0, MultBusy=0, MultDone=0, MfResultD=0 for mfRegD 01/10.
REQ-028 reset mid-operation (BUSY or DONE) abandons the multiply; no HI/LO update occurs.
REQ-029 reset overrides startMultE on the same edge.

Structure
REQ-030 Shared package holds the state enum (IDLE/BUSY/DONE) and the mfReg encodings (MF_NONE=00, MF_HI=01, MF_LO=10).
REQ-031 One sub-module mult_shift_add: operand/accumulator registers and one-iteration shift-add datapath, controlled by load/step enables from the FSM.
REQ-032 Counter width = clog2(WIDTH)+1; no combinational multiply operator on the full product.

Verification
REQ-033 Unsigned 0xFFFFFFFF x 0xFFFFFFFF, start at edge N -> MultDone high cycle N+32, HiOut=0xFFFFFFFE, LoOut=0x00000001 from edge N+33.
REQ-034 Signed -3 (0xFFFFFFFD) x 7 -> HiOut=0xFFFFFFFF, LoOut=0xFFFFFFEB; unsigned same operands -> HiOut=0x00000006, LoOut=0xFFFFFFEB.
REQ-035 Signed 0x80000000 x 0x80000000 -> HiOut=0x40000000, LoOut=0x00000000.
REQ-036 mfRegD=10 held from BUSY cycle 5 -> MultStall=1 until IDLE, then MultStall=0 and MfResultD=new LoOut.
REQ-037 reset=0 at BUSY cycle 10 -> next cycle IDLE, HiOut=LoOut=0, MultBusy=0; subsequent 2 x 3 gives LoOut=6.
REQ-038 Second startMultE (5 x 5) held while BUSY -> not accepted until IDLE, MultStall=1 throughout; first result intact, second gives LoOut=25.
